fetch_stage: RTL and testbench

//  F-stage of the 5-stage MIPS pipeline: owns the PC register, selects next PC (seq/branch/eret/exception),

---
 rtl/cpu_defs_pkg.sv | 16 +
 rtl/pc_reg.sv | 42 ++++
 rtl/fetch_stage.sv | 83 ++++++++
 tb/tb_fetch_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU constants for the fetch stage: reset/exception vectors, legal IM window, NOP word.
package cpu_defs;

   localparam logic [31:0] PC_RESET  = 32'h0000_3000;
   localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
   localparam logic [31:0] IM_LO     = 32'h0000_3000;
   localparam logic [31:0] IM_HI     = 32'h0000_6ffc;
   localparam logic [4:0]  EXC_ADEL  = 5'd4;
   localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

   // Misaligned or outside the instruction-memory window.
   function automatic logic fetch_addr_bad(input logic [31:0] addr);
      return (addr[1:0] != 2'b00) || (addr < IM_LO) || (addr > IM_HI);
   endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with the next-PC priority mux (exception > stall > eret > branch > seq).
module pc_reg
   import cpu_defs::*;
(
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        en_i,
   input  logic        req_i,
   input  logic        eret_i,
   input  logic [31:0] epc_i,
   input  logic        br_taken_i,
   input  logic [31:0] target_i,
   output logic [31:0] pc_o
);

   logic [31:0] pc_d, pc_q;

   always_comb begin
      pc_d = pc_q + 32'd4;
      // Exception redirect must not be blocked by a hazard stall.
      if (req_i) begin
         pc_d = EXC_ENTRY;
      end else if (!en_i) begin
         pc_d = pc_q;
      end else if (eret_i) begin
         pc_d = epc_i;
      end else if (br_taken_i) begin
         pc_d = target_i;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         pc_q <= PC_RESET;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS F-stage: PC, IM address, AdEL check, delay-slot tag and eret squash.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
   import cpu_defs::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        Req,
   input  logic        D_eret,
   input  logic [31:0] EPC,
   input  logic        D_br_taken,
   input  logic [31:0] D_target,
   input  logic        D_is_br,
   input  logic [31:0] i_inst_rdata,
   output logic [31:0] i_inst_addr,
   output logic [31:0] F_pc,
   output logic [31:0] F_instr,
   output logic        AdEL_F,
   output logic        F_BD
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch,
   output logic [31:0] perf_stall
`endif
);

   logic [31:0] pc;
   logic        addr_bad;

   pc_reg u_pc_reg (
      .clk_i      (clk),
      .reset_i    (reset),
      .en_i       (en),
      .req_i      (Req),
      .eret_i     (D_eret),
      .epc_i      (EPC),
      .br_taken_i (D_br_taken),
      .target_i   (D_target),
      .pc_o       (pc)
   );

   assign addr_bad    = fetch_addr_bad(pc);
   assign i_inst_addr = pc;
   assign F_pc        = pc;

   // eret has no delay slot: whatever sits in F is squashed to a NOP.
   always_comb begin
      AdEL_F  = addr_bad & ~D_eret;
      F_BD    = D_is_br & ~D_eret;
      F_instr = (D_eret || addr_bad) ? INSTR_NOP : i_inst_rdata;
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_d, perf_fetch_q;
   logic [31:0] perf_stall_d, perf_stall_q;

   always_comb begin
      perf_fetch_d = perf_fetch_q;
      perf_stall_d = perf_stall_q;
      if (en && !Req && !AdEL_F && (perf_fetch_q != 32'hffff_ffff)) begin
         perf_fetch_d = perf_fetch_q + 32'd1;
      end
      if (!en && !Req && (perf_stall_q != 32'hffff_ffff)) begin
         perf_stall_d = perf_stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetch_q <= 32'd0;
         perf_stall_q <= 32'd0;
      end else begin
         perf_fetch_q <= perf_fetch_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_fetch = perf_fetch_q;
   assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written reset/perf
// sequences and a randomized run against a behavioural PC model.
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_PC = 32'h0000_4180;

   logic        clk = 1'b0;
   logic        reset, en, Req, D_eret, D_br_taken, D_is_br;
   logic [31:0] EPC, D_target, i_inst_rdata, i_inst_addr, F_pc, F_instr;
   logic        AdEL_F, F_BD;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch, perf_stall;
`endif

   fetch_stage dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .Req          (Req),
      .D_eret       (D_eret),
      .EPC          (EPC),
      .D_br_taken   (D_br_taken),
      .D_target     (D_target),
      .D_is_br      (D_is_br),
      .i_inst_rdata (i_inst_rdata),
      .i_inst_addr  (i_inst_addr),
      .F_pc         (F_pc),
      .F_instr      (F_instr),
      .AdEL_F       (AdEL_F),
      .F_BD         (F_BD)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetch   (perf_fetch),
      .perf_stall   (perf_stall)
`endif
   );

   always #5 clk = ~clk;

   // Instruction memory: a fixed, never-zero word derived from the address.
   function automatic logic [31:0] im_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h0bad_0000;
   endfunction

   assign i_inst_rdata = im_word(i_inst_addr);

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] m_pc;
   int unsigned m_fetch, m_stall;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit legal(input logic [31:0] a);
      return (a % 4 == 0) && (a >= 32'h3000) && (a <= 32'h6ffc);
   endfunction

   function automatic bit exp_adel();
      return !D_eret && !legal(m_pc);
   endfunction

   task automatic check_outputs(input string tag);
      logic [31:0] instr;
      instr = (D_eret || !legal(m_pc)) ? 32'h0 : im_word(m_pc);
      chk({tag, ".F_pc"}, F_pc, m_pc);
      chk({tag, ".i_inst_addr"}, i_inst_addr, m_pc);
      chk({tag, ".AdEL_F"}, {31'd0, AdEL_F}, {31'd0, exp_adel()});
      chk({tag, ".F_BD"}, {31'd0, F_BD}, {31'd0, D_is_br && !D_eret});
      chk({tag, ".F_instr"}, F_instr, instr);
`ifdef FETCH_PERF_CNT_EN
      chk({tag, ".perf_fetch"}, perf_fetch, m_fetch);
      chk({tag, ".perf_stall"}, perf_stall, m_stall);
`endif
   endtask

   // One clock edge; the model applies the architectural next-PC rules.
   task automatic advance();
      logic [31:0] nxt;
      if (Req)             nxt = EXC_PC;
      else if (!en)        nxt = m_pc;
      else if (D_eret)     nxt = EPC;
      else if (D_br_taken) nxt = D_target;
      else                 nxt = m_pc + 32'd4;
      if (en && !Req && !exp_adel()) m_fetch++;
      if (!en && !Req)               m_stall++;
      @(posedge clk);
      m_pc = nxt;
      #1;
   endtask

   task automatic drive(input logic e, input logic rq, input logic er, input logic br,
                        input logic isbr, input logic [31:0] epc, input logic [31:0] tgt);
      en = e; Req = rq; D_eret = er; D_br_taken = br; D_is_br = isbr;
      EPC = epc; D_target = tgt;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      m_pc = RST_PC; m_fetch = 0; m_stall = 0;
      #1;
      check_outputs("reset");
      @(negedge clk);
      reset = 1'b0;
   endtask

   typedef struct {
      logic        en, req, eret, br, isbr;
      logic [31:0] epc, tgt, now_pc, next_pc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic e, input logic rq, input logic er, input logic br,
                               input logic isbr, input logic [31:0] epc,
                               input logic [31:0] tgt, input logic [31:0] now_pc,
                               input logic [31:0] next_pc);
      vec_t v;
      v.en = e; v.req = rq; v.eret = er; v.br = br; v.isbr = isbr;
      v.epc = epc; v.tgt = tgt; v.now_pc = now_pc; v.next_pc = next_pc;
      return v;
   endfunction

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 5))
         0:       return 32'h3000 + ($urandom_range(0, 32'hfff) << 2) + $urandom_range(1, 3);
         1:       return $urandom & 32'hffff_fffc;
         2:       return 32'h6ffc + (32'($urandom_range(0, 1)) << 2);
         default: return 32'h3000 + ($urandom_range(0, 32'hfff) << 2);
      endcase
   endfunction

   initial begin
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      m_pc = RST_PC; m_fetch = 0; m_stall = 0;
      #2;
      check_outputs("por");
      @(negedge clk);
      reset = 1'b0;

      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h3000, 32'h3004));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h3004, 32'h3008));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h3008, 32'h300c));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h300c, 32'h3010));
      for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h3010, 32'h3010));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h3010, 32'h3014));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h3014, 32'h3018));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h3018, 32'h301c));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h301c, 32'h3020));
      vecs.push_back(mk(1, 0, 0, 1, 1, 0, 32'h3400, 32'h3020, 32'h3400));
      vecs.push_back(mk(1, 0, 0, 1, 1, 0, 32'h3402, 32'h3400, 32'h3402));
      vecs.push_back(mk(1, 0, 0, 1, 1, 0, 32'h7000, 32'h3402, 32'h7000));
      vecs.push_back(mk(1, 0, 0, 1, 0, 0, 32'h6ffc, 32'h7000, 32'h6ffc));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h6ffc, 32'h7000));
      vecs.push_back(mk(0, 1, 1, 0, 1, 32'h3100, 0, 32'h7000, 32'h4180));
      vecs.push_back(mk(1, 0, 1, 0, 1, 32'h3100, 0, 32'h4180, 32'h3100));
      vecs.push_back(mk(1, 1, 0, 1, 1, 0, 32'h3400, 32'h3100, 32'h4180));
      vecs.push_back(mk(1, 0, 0, 1, 0, 0, 32'hffff_fffc, 32'h4180, 32'hffff_fffc));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'hffff_fffc, 32'h0000_0000));
      vecs.push_back(mk(1, 0, 1, 0, 0, 32'h3000, 0, 32'h0000_0000, 32'h3000));

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].en, vecs[i].req, vecs[i].eret, vecs[i].br, vecs[i].isbr,
               vecs[i].epc, vecs[i].tgt);
         #1;
         chk($sformatf("vec%0d.now", i), F_pc, vecs[i].now_pc);
         check_outputs($sformatf("vec%0d", i));
         advance();
         chk($sformatf("vec%0d.next", i), F_pc, vecs[i].next_pc);
      end

      // Asynchronous reset mid-cycle: PC returns immediately, before any edge.
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #2 reset = 1'b1;
      #1;
      chk("async_rst.F_pc", F_pc, 32'h3000);
      m_pc = RST_PC; m_fetch = 0; m_stall = 0;
      check_outputs("async_rst");
      #1 reset = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         advance();
         chk($sformatf("post_rst%0d", i), F_pc, 32'h3000 + 32'(4 * i));
      end

`ifdef FETCH_PERF_CNT_EN
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(i < 5, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
         advance();
         @(negedge clk);
      end
      chk("perf.fetch5", perf_fetch, 32'd5);
      chk("perf.stall3", perf_stall, 32'd3);
      reset = 1'b1;
      #1;
      chk("perf.fetch_rst", perf_fetch, 32'd0);
      chk("perf.stall_rst", perf_stall, 32'd0);
      reset = 1'b0;
`endif

      do_reset();
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 2) == 0, rand_addr(), rand_addr());
         #1;
         check_outputs($sformatf("rnd%0d", i));
         advance();
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
